// File: rtl/height_frame_writer_pkg.sv
// Shared constants, bank encoding and FSM state type for the column-height
// ping-pong buffer writer.
package height_frame_writer_pkg;

   localparam int WIDTH    = 640;  // columns per frame, one beat each
   localparam int HEIGHT   = 480;  // tallest wall the renderer can draw
   localparam int COL_W    = 10;
   localparam int HEIGHT_W = 9;
   localparam int DROP_W   = 8;

   // Bank-select encoding for the two halves of the ping-pong buffer.
   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;

   // FILL: collecting beats for the write bank.
   // DONE: write bank is complete, waiting for the display frame boundary.
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/height_frame_writer_height_clamp.sv
// Registered min(height, MAX_HEIGHT) on the buffer write data path.
module height_clamp #(
   parameter int HEIGHT_W   = 9,
   parameter int MAX_HEIGHT = 480
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_en,
   input  logic [HEIGHT_W-1:0] i_height,
   output logic [HEIGHT_W-1:0] o_height
);

   localparam logic [HEIGHT_W-1:0] LP_MAX = HEIGHT_W'(MAX_HEIGHT);

   logic [HEIGHT_W-1:0] r_height;

   // Capture the clamped height on each accepted beat; hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_height <= '0;
      end else if (i_en) begin
         r_height <= (i_height > LP_MAX) ? LP_MAX : i_height;
      end
   end

   assign o_height = r_height;

endmodule

// File: rtl/height_frame_writer.sv
// Writer side of the ping-pong column-height buffer. Collects one height per
// screen column, writes it to the current write bank one cycle later, and
// publishes the bank to the renderer only at a display frame boundary.
//
// Handshake: a beat transfers on every rising clk edge where height_valid and
// height_ready are both 1. height_ready depends only on the FSM state, never
// on height_valid; the producer must hold the beat stable until it transfers.
module height_frame_writer #(
   parameter int WIDTH      = height_frame_writer_pkg::WIDTH,
   parameter int COL_W      = height_frame_writer_pkg::COL_W,
   parameter int HEIGHT_W   = height_frame_writer_pkg::HEIGHT_W,
   parameter int MAX_HEIGHT = height_frame_writer_pkg::HEIGHT,
   parameter int DROP_W     = height_frame_writer_pkg::DROP_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_sync,
   input  logic                height_valid,
   output logic                height_ready,
   input  logic [HEIGHT_W-1:0] height_data,
   input  logic [COL_W-1:0]    height_col,
   output logic                frame_request,
   output logic                wr_en,
   output logic                wr_bank,
   output logic [COL_W-1:0]    wr_addr,
   output logic [HEIGHT_W-1:0] wr_data,
   output logic                display_bank,
   output logic                display_valid,
   output logic [DROP_W-1:0]   dropped_frames,
   output logic                seq_error,
   output logic                dbg_state
);

   import height_frame_writer_pkg::*;

   localparam logic [COL_W-1:0]  LP_LAST_COL = COL_W'(WIDTH - 1);
   localparam logic [DROP_W-1:0] LP_DROP_MAX = '1;

   state_t              r_state;
   state_t              w_state_next;
   logic [COL_W-1:0]    r_col_cnt;
   logic                r_cur_bank;      // bank currently being filled
   logic                r_wr_bank;       // bank tagged onto the visible write
   logic                r_display_bank;
   logic                r_display_valid;
   logic                r_wr_en;
   logic [COL_W-1:0]    r_wr_addr;
   logic                r_seq_error;
   logic                r_frame_request;
   logic                r_rst_seen;
   logic [DROP_W-1:0]   r_dropped;

   logic                w_ready;
   logic                w_accept;
   logic                w_last_beat;
   logic                w_swap;
   logic                w_drop;
   logic                w_cur_bank_next;

   assign w_accept        = height_valid && (r_state == ST_FILL);
   assign w_last_beat     = (r_col_cnt == LP_LAST_COL);
   assign w_cur_bank_next = w_swap ? ~r_cur_bank : r_cur_bank;

   // Next state, ready, swap and drop decisions.
   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_swap       = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         ST_FILL: begin
            w_ready = 1'b1;
            if (w_accept && w_last_beat) begin
               // Last beat together with frame_sync counts as a complete frame.
               if (frame_sync) begin
                  w_swap       = 1'b1;
                  w_state_next = ST_FILL;
               end else begin
                  w_state_next = ST_DONE;
               end
            end else if (frame_sync) begin
               w_drop = 1'b1;
            end
         end
         ST_DONE: begin
            if (frame_sync) begin
               w_swap       = 1'b1;
               w_state_next = ST_FILL;
            end
         end
         default: w_state_next = ST_FILL;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Column counter, write strobe/address and column-order checking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col_cnt   <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_seq_error <= 1'b0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_wr_addr <= r_col_cnt;
            r_col_cnt <= w_last_beat ? '0 : r_col_cnt + 1'b1;
            if (height_col != r_col_cnt) begin
               r_seq_error <= 1'b1;
            end
         end
      end
   end

   // Bank bookkeeping; a write accepted on the swap edge keeps its old bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur_bank      <= BANK0;
         r_wr_bank       <= BANK0;
         r_display_bank  <= BANK1;
         r_display_valid <= 1'b0;
      end else begin
         r_cur_bank <= w_cur_bank_next;
         r_wr_bank  <= w_accept ? r_cur_bank : w_cur_bank_next;
         if (w_swap) begin
            r_display_bank  <= r_cur_bank;
            r_display_valid <= 1'b1;
         end
      end
   end

   // Frame request: once after reset release, once after every swap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_request <= 1'b0;
         r_rst_seen      <= 1'b1;
      end else begin
         r_frame_request <= r_rst_seen | w_swap;
         r_rst_seen      <= 1'b0;
      end
   end

   // Saturating count of frame boundaries that found no complete frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dropped <= '0;
      end else if (w_drop && (r_dropped != LP_DROP_MAX)) begin
         r_dropped <= r_dropped + 1'b1;
      end
   end

   height_clamp #(
      .HEIGHT_W   (HEIGHT_W),
      .MAX_HEIGHT (MAX_HEIGHT)
   ) u_clamp (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_accept),
      .i_height (height_data),
      .o_height (wr_data)
   );

   assign height_ready   = w_ready;
   assign frame_request  = r_frame_request;
   assign wr_en          = r_wr_en;
   assign wr_bank        = r_wr_bank;
   assign wr_addr        = r_wr_addr;
   assign display_bank   = r_display_bank;
   assign display_valid  = r_display_valid;
   assign dropped_frames = r_dropped;
   assign seq_error      = r_seq_error;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_height_frame_writer.sv
// Directed bench for height_frame_writer: reset, full frames, clamping,
// dropped frames, swap on the final beat, column-order error, mid-fill reset.
module tb_height_frame_writer;

   import height_frame_writer_pkg::*;

   localparam int LP_W = 640;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_sync = 1'b0;
   logic       height_valid = 1'b0;
   logic       height_ready;
   logic [8:0] height_data = '0;
   logic [9:0] height_col = '0;
   logic       frame_request;
   logic       wr_en;
   logic       wr_bank;
   logic [9:0] wr_addr;
   logic [8:0] wr_data;
   logic       display_bank;
   logic       display_valid;
   logic [7:0] dropped_frames;
   logic       seq_error;
   logic       dbg_state;

   height_frame_writer dut (
      .clk            (clk),
      .reset          (reset),
      .frame_sync     (frame_sync),
      .height_valid   (height_valid),
      .height_ready   (height_ready),
      .height_data    (height_data),
      .height_col     (height_col),
      .frame_request  (frame_request),
      .wr_en          (wr_en),
      .wr_bank        (wr_bank),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .display_bank   (display_bank),
      .display_valid  (display_valid),
      .dropped_frames (dropped_frames),
      .seq_error      (seq_error),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int req_cnt = 0;
   int wr_cnt  = 0;
   logic [19:0] exp_q[$];   // {bank, addr[9:0], data[8:0]}
   logic m_bank = 1'b0;
   int   m_col  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] clamp_h(input logic [8:0] h);
      return (h > 9'd480) ? 9'd480 : h;
   endfunction

   // Every write is matched against the expected queue; frame_request is
   // counted and must never appear while the writer holds a finished bank.
   always @(negedge clk) begin
      if (frame_request) begin
         req_cnt++;
         check("req_not_in_done", {31'b0, dbg_state}, {31'b0, ST_FILL});
      end
      if (wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got bank %0d addr %0d data %0d, expected no write",
                     wr_bank, wr_addr, wr_data);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("write", {12'b0, wr_bank, wr_addr, wr_data}, {12'b0, e});
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_beat(input int tag, input logic [8:0] data, input logic fs);
      height_valid = 1'b1;
      height_col   = 10'(tag);
      height_data  = data;
      frame_sync   = fs;
      exp_q.push_back({m_bank, 10'(m_col), clamp_h(data)});
      m_col = (m_col + 1) % LP_W;
      @(posedge clk);
      #1;
      frame_sync = 1'b0;
   endtask

   task automatic fill(input int from, input int to);
      for (int c = from; c <= to; c++) begin
         send_beat(c, 9'(c), 1'b0);
      end
      height_valid = 1'b0;
   endtask

   task automatic idle();
      height_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_sync();
      height_valid = 1'b0;
      frame_sync   = 1'b1;
      @(posedge clk);
      #1;
      frame_sync = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"},   {31'b0, frame_request},  32'd0);
      check({tag, "_wr_en"}, {31'b0, wr_en},          32'd0);
      check({tag, "_wbank"}, {31'b0, wr_bank},        32'd0);
      check({tag, "_waddr"}, {22'b0, wr_addr},        32'd0);
      check({tag, "_wdata"}, {23'b0, wr_data},        32'd0);
      check({tag, "_dbank"}, {31'b0, display_bank},   32'd1);
      check({tag, "_dval"},  {31'b0, display_valid},  32'd0);
      check({tag, "_drop"},  {24'b0, dropped_frames}, 32'd0);
      check({tag, "_seq"},   {31'b0, seq_error},      32'd0);
      check({tag, "_ready"}, {31'b0, height_ready},   32'd1);
   endtask

   // ---------------- clamp vector table ----------------
   typedef struct {
      logic [8:0] data;
      logic [8:0] exp;
   } clamp_vec_t;

   clamp_vec_t vecs[6];

   // ---------------- test sequence ----------------
   initial begin
      int r0;
      int w0;

      vecs[0] = '{data: 9'd511, exp: 9'd480};
      vecs[1] = '{data: 9'd479, exp: 9'd479};
      vecs[2] = '{data: 9'd480, exp: 9'd480};
      vecs[3] = '{data: 9'd481, exp: 9'd480};
      vecs[4] = '{data: 9'd0,   exp: 9'd0};
      vecs[5] = '{data: 9'd300, exp: 9'd300};

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");

      // Release: frame_request for exactly one cycle
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rel_req_hi", {31'b0, frame_request}, 32'd1);
      @(posedge clk);
      #1;
      check("rel_req_lo", {31'b0, frame_request}, 32'd0);
      m_bank = 1'b0;
      m_col  = 0;

      // Frame A: 640 beats, data = column, into bank 0
      w0 = wr_cnt;
      fill(0, LP_W - 1);
      idle();
      check("a_writes", wr_cnt - w0, 32'd640);
      check("a_ready_done", {31'b0, height_ready}, 32'd0);
      check("a_dval_pre", {31'b0, display_valid}, 32'd0);

      // Beat offered in DONE must not be taken
      height_valid = 1'b1;
      height_col   = 10'd0;
      height_data  = 9'd7;
      repeat (3) @(posedge clk);
      #1;
      height_valid = 1'b0;
      check("a_no_write_done", {31'b0, wr_en}, 32'd0);

      r0 = req_cnt;
      pulse_sync();
      check("a_dbank", {31'b0, display_bank}, 32'd0);
      check("a_dval", {31'b0, display_valid}, 32'd1);
      check("a_ready_fill", {31'b0, height_ready}, 32'd1);
      idle();
      idle();
      check("a_wbank", {31'b0, wr_bank}, 32'd1);
      check("a_req_once", req_cnt - r0, 32'd1);
      m_bank = 1'b1;

      // Frame B: clamp vectors, then frame_sync mid-fill
      for (int i = 0; i < 6; i++) begin
         send_beat(i, vecs[i].data, 1'b0);
         check($sformatf("clamp_%0d", i), {23'b0, wr_data}, {23'b0, vecs[i].exp});
      end
      fill(6, 299);
      r0 = req_cnt;
      pulse_sync();
      check("b_drop", {24'b0, dropped_frames}, 32'd1);
      check("b_dbank_hold", {31'b0, display_bank}, 32'd0);
      check("b_wbank_hold", {31'b0, wr_bank}, 32'd1);
      check("b_ready", {31'b0, height_ready}, 32'd1);
      fill(300, LP_W - 1);
      check("b_req_none", req_cnt - r0, 32'd0);
      idle();
      pulse_sync();
      check("b_dbank_swap", {31'b0, display_bank}, 32'd1);
      idle();
      check("b_wbank_swap", {31'b0, wr_bank}, 32'd0);
      check("b_drop_keep", {24'b0, dropped_frames}, 32'd1);
      m_bank = 1'b0;

      // Frame C: final beat together with frame_sync
      fill(0, LP_W - 2);
      r0 = req_cnt;
      send_beat(LP_W - 1, 9'd100, 1'b1);
      height_valid = 1'b0;
      m_bank = 1'b1;
      check("c_last_en", {31'b0, wr_en}, 32'd1);
      check("c_last_addr", {22'b0, wr_addr}, 32'd639);
      check("c_last_bank", {31'b0, wr_bank}, 32'd0);
      check("c_dbank", {31'b0, display_bank}, 32'd0);
      check("c_req", {31'b0, frame_request}, 32'd1);
      check("c_drop", {24'b0, dropped_frames}, 32'd1);
      check("c_ready", {31'b0, height_ready}, 32'd1);
      idle();
      check("c_wbank_new", {31'b0, wr_bank}, 32'd1);
      check("c_req_once", req_cnt - r0, 32'd1);

      // Frame D: out-of-order tag, then reset mid-fill
      fill(0, 3);
      check("d_seq_clean", {31'b0, seq_error}, 32'd0);
      send_beat(5, 9'd55, 1'b0);
      check("d_seq_set", {31'b0, seq_error}, 32'd1);
      check("d_seq_addr", {22'b0, wr_addr}, 32'd4);
      fill(5, 99);
      idle();
      check("d_seq_sticky", {31'b0, seq_error}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("mid");
      check("mid_state", {31'b0, dbg_state}, {31'b0, ST_FILL});
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rel_req", {31'b0, frame_request}, 32'd1);
      m_bank = 1'b0;
      m_col  = 0;
      send_beat(0, 9'd123, 1'b0);
      height_valid = 1'b0;
      check("mid_restart_addr", {22'b0, wr_addr}, 32'd0);
      check("mid_restart_bank", {31'b0, wr_bank}, 32'd0);
      idle();
      idle();

      check("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
